// File: rtl/motor_pwm_ctrl_pkg.sv
// Shared register map, H-bridge direction codes and the direction-to-pin mapping
// for the memory-mapped motor PWM controller.
package motor_pwm_ctrl_pkg;

  localparam int NUM_CH = 4;

  localparam logic [2:0] OFF_DUTY0  = 3'd0;
  localparam logic [2:0] OFF_DUTY1  = 3'd1;
  localparam logic [2:0] OFF_DUTY2  = 3'd2;
  localparam logic [2:0] OFF_DUTY3  = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;
  localparam logic [2:0] OFF_KICK   = 3'd6;

  typedef enum logic [1:0] {
    DIR_COAST = 2'b00,
    DIR_FWD   = 2'b01,
    DIR_REV   = 2'b10,
    DIR_BRAKE = 2'b11
  } dir_e;

  // {IN1,IN2} for one bridge
  function automatic logic [1:0] dir_to_pins(input logic [1:0] dir);
    logic [1:0] p;
    p = 2'b00;
    case (dir)
      DIR_FWD:   p = 2'b10;
      DIR_REV:   p = 2'b01;
      DIR_BRAKE: p = 2'b11;
      default:   p = 2'b00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/motor_pwm_ctrl_pwm_channel.sv
// One PWM/H-bridge channel: pending and active duty/dir, period-boundary shadow
// load, counter compare and registered pin drivers.
module pwm_channel
  import motor_pwm_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_wr,
  input  logic [9:0] i_wdata,
  input  logic       i_enable,
  input  logic       i_boundary,
  input  logic       i_drive,
  input  logic [7:0] i_pwm_cnt,
  output logic [9:0] o_pend,
  output logic       o_pwm,
  output logic [1:0] o_dir
);

  logic [7:0] r_pend_duty, r_act_duty;
  logic [1:0] r_pend_dir, r_act_dir;
  logic       r_pwm;
  logic [1:0] r_dir;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend_duty <= '0;
      r_pend_dir  <= '0;
      r_act_duty  <= '0;
      r_act_dir   <= '0;
      r_pwm       <= 1'b0;
      r_dir       <= 2'b00;
    end else begin
      if (i_wr) begin
        r_pend_duty <= i_wdata[7:0];
        r_pend_dir  <= i_wdata[9:8];
      end
      // Active copies the pre-edge pending value, so a boundary-cycle write waits one period.
      if (!i_enable || i_boundary) begin
        r_act_duty <= r_pend_duty;
        r_act_dir  <= r_pend_dir;
      end
      r_pwm <= i_drive && (i_pwm_cnt < r_act_duty);
      r_dir <= i_drive ? dir_to_pins(r_act_dir) : 2'b00;
    end
  end

  assign o_pend = {r_pend_dir, r_pend_duty};
  assign o_pwm  = r_pwm;
  assign o_dir  = r_dir;

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Memory-mapped 4-channel PWM / H-bridge controller: bus decode, prescaler,
// shared PWM counter, bus-activity watchdog and the channel array.
module motor_pwm_ctrl
  import motor_pwm_ctrl_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR   = 12'hF00,
  parameter logic [15:0] PRESC_RESET = 16'd0,
  parameter logic [23:0] WDT_CYCLES  = 24'd5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic [3:0]  PWMSignals,
  output logic [7:0]  Directions
);

  logic [12:0] w_off_full;
  logic [2:0]  w_off;
  logic        w_wr, w_kick, w_tick, w_boundary, w_drive;
  logic [NUM_CH-1:0][9:0] w_pend;
  logic        w_unused;

  logic        r_enable, r_trip;
  logic [15:0] r_presc, r_pre_cnt;
  logic [7:0]  r_pwm_cnt;
  logic [23:0] r_wdt_cnt;

  // Widened subtract: addresses below BASE_ADDR wrap high and fail the range test.
  assign w_off_full = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign sel        = (w_off_full < 13'd8);
  assign w_off      = w_off_full[2:0];
  assign w_wr       = wren && sel;
  assign w_kick     = w_wr && (w_off == OFF_KICK) && wdata[0];
  assign w_tick     = r_enable && (r_pre_cnt >= r_presc);
  assign w_boundary = w_tick && (r_pwm_cnt == 8'hFF);
  assign w_drive    = r_enable && !r_trip;
  assign w_unused   = ^wdata[31:24];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_enable <= 1'b0;
      r_presc  <= PRESC_RESET;
    end else if (w_wr && (w_off == OFF_CTRL)) begin
      r_enable <= wdata[0];
      r_presc  <= wdata[23:8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (!r_enable) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end else begin
      r_pre_cnt <= r_pre_cnt + 16'd1;
    end
  end

  // KICK outranks expiry; any other in-range write only reloads the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wdt_cnt <= WDT_CYCLES;
      r_trip    <= 1'b0;
    end else if (w_kick) begin
      r_wdt_cnt <= WDT_CYCLES;
      r_trip    <= 1'b0;
    end else if (w_wr) begin
      r_wdt_cnt <= WDT_CYCLES;
    end else if (r_enable && !r_trip) begin
      if (r_wdt_cnt <= 24'd1) begin
        r_wdt_cnt <= '0;
        r_trip    <= 1'b1;
      end else begin
        r_wdt_cnt <= r_wdt_cnt - 24'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (!sel) begin
      rdata <= '0;
    end else begin
      case (w_off)
        OFF_DUTY0, OFF_DUTY1,
        OFF_DUTY2, OFF_DUTY3: rdata <= {22'd0, w_pend[w_off[1:0]]};
        OFF_CTRL:             rdata <= {8'd0, r_presc, 7'd0, r_enable};
        OFF_STATUS:           rdata <= {15'd0, r_enable, r_pwm_cnt, 7'd0, r_trip};
        default:              rdata <= '0;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel u_ch (
      .clock      (clock),
      .reset      (reset),
      .i_wr       (w_wr && (w_off == 3'(g))),
      .i_wdata    (wdata[9:0]),
      .i_enable   (r_enable),
      .i_boundary (w_boundary),
      .i_drive    (w_drive),
      .i_pwm_cnt  (r_pwm_cnt),
      .o_pend     (w_pend[g]),
      .o_pwm      (PWMSignals[g]),
      .o_dir      (Directions[2*g+1 -: 2])
    );
  end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Self-checking bench for motor_pwm_ctrl: randomized duty/dir traffic checked
// against per-period high counts and pin mappings derived from the register map.
module tb_motor_pwm_ctrl;

  localparam logic [11:0] BASE = 12'hF00;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wren  = 1'b0;
  logic [11:0] addr  = 12'hF05;
  logic [31:0] wdata = 32'd0;
  logic        sel;
  logic [31:0] rdata;
  logic [3:0]  PWMSignals;
  logic [7:0]  Directions;

  int n_pass  = 0;
  int n_total = 0;
  int hi[4];

  motor_pwm_ctrl #(
    .BASE_ADDR   (BASE),
    .PRESC_RESET (16'd0),
    .WDT_CYCLES  (24'd100)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wren       (wren),
    .addr       (addr),
    .wdata      (wdata),
    .sel        (sel),
    .rdata      (rdata),
    .PWMSignals (PWMSignals),
    .Directions (Directions)
  );

  always #5 clock = ~clock;

  // Reference pin pair per direction code: fwd 10, rev 01, brake 11, coast 00
  function automatic logic [1:0] pins(input logic [1:0] dir);
    logic [1:0] lut [4];
    lut[0] = 2'b00; lut[1] = 2'b10; lut[2] = 2'b01; lut[3] = 2'b11;
    return lut[dir];
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    addr = BASE + {9'd0, off}; wdata = d; wren = 1'b1;
    cyc();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] d);
    addr = BASE + {9'd0, off}; wren = 1'b0;
    cyc();
    d = rdata;
  endtask

  // Advance n cycles counting highs per channel; ka keeps the watchdog fed via offset 7.
  task automatic run(input int n, input bit ka);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int k = 0; k < n; k++) begin
      if (ka && (k % 50 == 0)) begin
        wren = 1'b1; addr = BASE + 12'd7; wdata = $urandom();
      end else begin
        wren = 1'b0; addr = BASE + 12'd5;
      end
      cyc();
      for (int c = 0; c < 4; c++) if (PWMSignals[c]) hi[c]++;
    end
    wren = 1'b0;
  endtask

  // Disable, load all four DUTY registers (junk in upper bits), then enable: counting starts at 0.
  task automatic start(input logic [15:0] presc, input logic [3:0][9:0] cfg);
    wr(3'd4, 32'd0);
    for (int c = 0; c < 4; c++) wr(3'(c), ($urandom() & 32'hFFFF_FC00) | {22'd0, cfg[c]});
    wr(3'd4, {8'd0, presc, 8'h01});
  endtask

  task automatic test_reset();
    logic [3:0][9:0] cfg;
    logic [31:0] d;
    cfg = '0; cfg[0] = {2'b01, 8'd128};
    start(16'd0, cfg);
    run(10, 1'b1);
    n_total++; if (PWMSignals[0] !== 1'b1) $display("FAIL reset_pre_pwm got %0b exp 1", PWMSignals[0]); else n_pass++;
    n_total++; if (rdata === 32'd0) $display("FAIL reset_pre_rdata got %0h exp nonzero", rdata); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++; if (PWMSignals !== 4'd0) $display("FAIL reset_pwm got %0h exp 0", PWMSignals); else n_pass++;
    n_total++; if (Directions !== 8'd0) $display("FAIL reset_dir got %0h exp 0", Directions); else n_pass++;
    n_total++; if (rdata !== 32'd0) $display("FAIL reset_rdata got %0h exp 0", rdata); else n_pass++;
    cyc(); cyc();
    reset = 1'b1;
    rd(3'd5, d);
    n_total++; if (d !== 32'd0) $display("FAIL reset_status got %0h exp 0", d); else n_pass++;
    rd(3'd4, d);
    n_total++; if (d !== 32'd0) $display("FAIL reset_ctrl got %0h exp 0", d); else n_pass++;
    rd(3'd0, d);
    n_total++; if (d !== 32'd0) $display("FAIL reset_duty0 got %0h exp 0", d); else n_pass++;
  endtask

  task automatic test_basic();
    logic [3:0][9:0] cfg;
    logic [31:0] d;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) cfg[c] = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
      if (r == 0) cfg[0] = 10'h140;
      start(16'd0, cfg);
      run(256, 1'b1);
      for (int c = 0; c < 4; c++) begin
        n_total++; if (hi[c] != int'(cfg[c][7:0])) $display("FAIL basic_highs r%0d ch%0d got %0d exp %0d", r, c, hi[c], cfg[c][7:0]); else n_pass++;
        n_total++; if (Directions[2*c +: 2] !== pins(cfg[c][9:8])) $display("FAIL basic_dir r%0d ch%0d got %b exp %b", r, c, Directions[2*c +: 2], pins(cfg[c][9:8])); else n_pass++;
      end
      for (int c = 0; c < 4; c++) begin
        rd(3'(c), d);
        n_total++; if (d !== {22'd0, cfg[c]}) $display("FAIL basic_readback r%0d ch%0d got %0h exp %0h", r, c, d, cfg[c]); else n_pass++;
      end
    end
  endtask

  task automatic test_extremes();
    logic [3:0][9:0] cfg;
    cfg = {{2'b01, 8'd128}, {2'b10, 8'd1}, {2'b11, 8'd255}, {2'b00, 8'd0}};
    start(16'd0, cfg);
    run(256, 1'b1);
    for (int c = 0; c < 4; c++) begin
      n_total++; if (hi[c] != int'(cfg[c][7:0])) $display("FAIL ext_highs ch%0d got %0d exp %0d", c, hi[c], cfg[c][7:0]); else n_pass++;
      n_total++; if (Directions[2*c +: 2] !== pins(cfg[c][9:8])) $display("FAIL ext_dir ch%0d got %b exp %b", c, Directions[2*c +: 2], pins(cfg[c][9:8])); else n_pass++;
    end
    start(16'd3, cfg);
    run(1024, 1'b1);
    for (int c = 0; c < 4; c++) begin
      n_total++; if (hi[c] != 4 * int'(cfg[c][7:0])) $display("FAIL presc3_highs ch%0d got %0d exp %0d", c, hi[c], 4 * int'(cfg[c][7:0])); else n_pass++;
    end
    run(1, 1'b0);
    n_total++; if (hi[2] != 1) $display("FAIL presc3_wrap ch2 got %0d exp 1", hi[2]); else n_pass++;
  endtask

  task automatic test_shadow();
    logic [3:0][9:0] cfg;
    int per[4];
    int wk[2];
    logic [9:0] wv[2];
    int exp_d;
    wk[0] = 100; wv[0] = {2'b01, 8'd200};
    wk[1] = 511; wv[1] = {2'b10, 8'd10};
    cfg = '0; cfg[1] = {2'b01, 8'd32};
    start(16'd0, cfg);
    for (int p = 0; p < 4; p++) per[p] = 0;
    for (int k = 0; k < 1024; k++) begin
      wren = 1'b0; addr = BASE + 12'd5;
      if (k == wk[0] || k == wk[1]) begin
        wren = 1'b1; addr = BASE + 12'd1; wdata = {22'd0, (k == wk[0]) ? wv[0] : wv[1]};
      end else if (k % 50 == 0) begin
        wren = 1'b1; addr = BASE + 12'd7; wdata = $urandom();
      end
      cyc();
      if (PWMSignals[1]) per[k / 256]++;
    end
    wren = 1'b0;
    // Period p uses the last write landing strictly before the boundary cycle 256p-1.
    for (int p = 0; p < 4; p++) begin
      exp_d = 32;
      for (int w = 0; w < 2; w++) if (p > 0 && wk[w] < 256 * p - 1) exp_d = int'(wv[w][7:0]);
      n_total++; if (per[p] != exp_d) $display("FAIL shadow_period%0d got %0d exp %0d", p, per[p], exp_d); else n_pass++;
    end
    n_total++; if (Directions[3:2] !== pins(wv[1][9:8])) $display("FAIL shadow_dir got %b exp %b", Directions[3:2], pins(wv[1][9:8])); else n_pass++;
  endtask

  task automatic test_watchdog();
    logic [3:0][9:0] cfg;
    logic [31:0] d;
    cfg = '0; cfg[0] = {2'b01, 8'd128};
    start(16'd0, cfg);
    addr = BASE + 12'd5; wren = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      cyc();
      if (k == 99) begin
        n_total++; if (rdata[0] !== 1'b0) $display("FAIL wdt_early got %0b exp 0", rdata[0]); else n_pass++;
        n_total++; if (PWMSignals[0] !== 1'b1) $display("FAIL wdt_early_pwm got %0b exp 1", PWMSignals[0]); else n_pass++;
      end
      if (k == 100) begin
        n_total++; if (rdata[0] !== 1'b1) $display("FAIL wdt_trip got %0b exp 1", rdata[0]); else n_pass++;
        n_total++; if (PWMSignals !== 4'd0) $display("FAIL wdt_pwm got %0h exp 0", PWMSignals); else n_pass++;
        n_total++; if (Directions !== 8'd0) $display("FAIL wdt_dir got %0h exp 0", Directions); else n_pass++;
      end
    end
    wr(3'd0, {22'd0, 2'b01, 8'd128});
    cyc(); cyc();
    rd(3'd5, d);
    n_total++; if (d[0] !== 1'b1) $display("FAIL wdt_duty_write got %0b exp 1", d[0]); else n_pass++;
    n_total++; if (PWMSignals !== 4'd0) $display("FAIL wdt_duty_pwm got %0h exp 0", PWMSignals); else n_pass++;
    wr(3'd6, 32'd0);
    rd(3'd5, d);
    n_total++; if (d[0] !== 1'b1) $display("FAIL wdt_kick0 got %0b exp 1", d[0]); else n_pass++;
    wr(3'd6, 32'd1);
    run(256, 1'b1);
    n_total++; if (hi[0] != 128) $display("FAIL wdt_resume_highs got %0d exp 128", hi[0]); else n_pass++;
    n_total++; if (Directions[1:0] !== 2'b10) $display("FAIL wdt_resume_dir got %b exp 10", Directions[1:0]); else n_pass++;
    rd(3'd5, d);
    n_total++; if (d[0] !== 1'b0) $display("FAIL wdt_cleared got %0b exp 0", d[0]); else n_pass++;
  endtask

  task automatic test_decode();
    logic [3:0][9:0] cfg;
    logic [31:0] d;
    for (int c = 0; c < 4; c++) cfg[c] = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
    start(16'd0, cfg);
    addr = BASE + 12'd8; #1;
    n_total++; if (sel !== 1'b0) $display("FAIL sel_above got %0b exp 0", sel); else n_pass++;
    addr = BASE - 12'd1; #1;
    n_total++; if (sel !== 1'b0) $display("FAIL sel_below got %0b exp 0", sel); else n_pass++;
    addr = BASE; #1;
    n_total++; if (sel !== 1'b1) $display("FAIL sel_base got %0b exp 1", sel); else n_pass++;
    addr = BASE + 12'd7; #1;
    n_total++; if (sel !== 1'b1) $display("FAIL sel_top got %0b exp 1", sel); else n_pass++;
    for (int k = 0; k < 105; k++) begin
      wren = 1'b1;
      addr = (k % 2 == 1) ? BASE + 12'd8 : BASE - 12'd1;
      wdata = $urandom();
      cyc();
      if (k == 0) begin
        n_total++; if (rdata !== 32'd0) $display("FAIL decode_rdata got %0h exp 0", rdata); else n_pass++;
      end
    end
    wren = 1'b0;
    rd(3'd5, d);
    n_total++; if (d[0] !== 1'b1) $display("FAIL decode_no_reload got %0b exp 1", d[0]); else n_pass++;
    rd(3'd0, d);
    n_total++; if (d !== {22'd0, cfg[0]}) $display("FAIL decode_duty0 got %0h exp %0h", d, cfg[0]); else n_pass++;
    wr(3'd6, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) cyc();
    n_total++; if (PWMSignals !== 4'd0 || Directions !== 8'd0 || rdata !== 32'd0)
      $display("FAIL por_outputs got %0h/%0h/%0h exp 0/0/0", PWMSignals, Directions, rdata); else n_pass++;
    #2 reset = 1'b1;
    cyc();
    test_reset();
    test_basic();
    test_extremes();
    test_shadow();
    test_watchdog();
    test_decode();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
